imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter addr_ins_width, default 32, width of mem_addr.
REQ-002 SHALL have parameter memory_width, default 32, width of one instruction word.
REQ-003 SHALL have parameter memory_height, default 512, number of instruction words that can be written.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a load.
REQ-007 SHALL have port num_words  input  $clog2(memory_height)+1  number of words to load; sampled only when start is accepted.
REQ-008 SHALL have port byte_valid  input  1  byte_data holds a valid byte.
REQ-009 SHALL have port byte_data  input  8  incoming program byte.
REQ-010 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-011 SHALL have port mem_we  output  1  instruction-memory write strobe.
REQ-012 SHALL have port mem_addr  output  addr_ins_width  word index being written.
REQ-013 SHALL have port mem_wdata  output  memory_width  assembled word.
REQ-014 SHALL have port busy  output  1  high from start acceptance until done.
REQ-015 SHALL have port done  output  1  one-cycle pulse when a load completes or is rejected.
REQ-016 SHALL have port error  output  1  sticky until the next accepted start; set on a rejected load.

Function
REQ-017 SHALL implement states IDLE, RECV, WRITE and DONE, plus CHECK when the checksum feature is compiled in.
REQ-018 SHALL accept start only in IDLE; start while busy SHALL be ignored.
REQ-019 On an accepted start, SHALL clear error, latch num_words, zero the byte and word counters and go to RECV.
REQ-020 SHALL go IDLE -> DONE with no writes when num_words == 0.
REQ-021 SHALL go IDLE -> DONE with error=1 and no writes when num_words > memory_height.
REQ-022 SHALL drive byte_ready=1 only in RECV; a byte transfers when byte_valid and byte_ready are both high.
REQ-023 SHALL assemble each word little-endian: 1st byte to [7:0], 2nd to [15:8], 3rd to [23:16], 4th to [31:24].
REQ-024 After the 4th byte transfers, SHALL enter WRITE on the next cycle.
REQ-025 In WRITE, SHALL assert mem_we for exactly one cycle with mem_addr equal to the word index and mem_wdata equal to the assembled word.
REQ-026 After WRITE, SHALL increment the word index and return to RECV while words remain, otherwise go to DONE (or CHECK when compiled in).
REQ-027 The last word SHALL be written at address num_words-1; the address SHALL never wrap or exceed memory_height-1.
REQ-028 In DONE, SHALL pulse done for one cycle, then go to IDLE with busy=0.
REQ-029 byte_valid gaps in RECV SHALL stall the loader without losing partial bytes.

Reset
REQ-030 When rst_n=0 at a clock edge, SHALL enter IDLE with byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0 and error=0.
REQ-031 A reset mid-load SHALL abort the load; no mem_we SHALL occur after the reset edge, and partial bytes SHALL be discarded.

Configuration
REQ-032 With macro IMEM_LOADER_CHECKSUM_EN defined, SHALL keep a running XOR of all written words.
REQ-033 With IMEM_LOADER_CHECKSUM_EN defined, SHALL receive one further 4-byte word in CHECK, compare it with the running XOR, set error=1 on mismatch, then go to DONE.
REQ-034 The checksum word SHALL never be written to memory.
REQ-035 Without IMEM_LOADER_CHECKSUM_EN, no CHECK state or checksum logic SHALL exist.

Structure
REQ-036 SHALL place the state enum typedef and the byte-per-word constant (4) in the shared package imem_pkg.
REQ-037 SHALL use one sub-module, byte_assembler: a 2-bit byte counter and shift register that outputs the word plus a word_valid pulse.

Verification
REQ-038 Bench SHALL cover: num_words=1, bytes b3 82 41 00 -> single mem_we, mem_addr=0, mem_wdata=32'h004182b3, then a done pulse.
REQ-039 Bench SHALL cover: num_words=7 streaming the words 004182b3, 40418333, 004193b3, 0041c433, 0041d4b3, 0041e533, 0041f5b3 -> seven writes at addresses 0..6 with matching data.
REQ-040 Bench SHALL cover: num_words=0 -> done two cycles after start, no mem_we, error=0; num_words=513 -> done, error=1, no mem_we.
REQ-041 Bench SHALL cover: byte_valid toggled every other cycle with num_words=2 -> same two writes as with a continuous stream; a start pulse mid-load is ignored.
REQ-042 Bench SHALL cover: rst_n=0 after 6 of 8 bytes -> exactly one write observed, all outputs at reset values, and a fresh load afterwards succeeds.
REQ-043 Bench SHALL cover, with IMEM_LOADER_CHECKSUM_EN defined: words 1 and 2 with checksum 3 -> error=0; same words with checksum 4 -> error=1.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
// IMEM_LOADER_CHECKSUM_EN adds the CHECK state used by the trailing checksum word.
package imem_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE
  } state_e;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Packs a little-endian byte stream into words. word_o/word_valid_o present the
// completed word combinationally in the cycle its last byte transfers.
module byte_assembler
  import imem_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr_i,
  input  logic                          byte_en_i,
  input  logic [7:0]                    byte_i,
  output logic [8*BYTES_PER_WORD-1:0]   word_o,
  output logic                          word_valid_o
);

  localparam int SH_W = 8 * (BYTES_PER_WORD - 1);

  logic [1:0]      cnt_q, cnt_d;
  logic [SH_W-1:0] sh_q, sh_d;

  always_comb begin
    cnt_d = cnt_q;
    sh_d  = sh_q;
    if (clr_i) begin
      cnt_d = '0;
      sh_d  = '0;
    end else if (byte_en_i) begin
      cnt_d = cnt_q + 2'd1;
      // Newest byte enters at the top, so the first byte ends up in [7:0]
      sh_d  = {byte_i, sh_q[SH_W-1:8]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sh_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
    end
  end

  assign word_o       = {byte_i, sh_q};
  assign word_valid_o = byte_en_i && !clr_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory one assembled word at a time.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum word.
module imem_loader
  import imem_pkg::*;
#(
  parameter int addr_ins_width = 32,
  parameter int memory_width   = 32,
  parameter int memory_height  = 512
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [$clog2(memory_height):0]       num_words,
  input  logic                                 byte_valid,
  input  logic [7:0]                           byte_data,
  output logic                                 byte_ready,
  output logic                                 mem_we,
  output logic [addr_ins_width-1:0]            mem_addr,
  output logic [memory_width-1:0]              mem_wdata,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 error
);

  localparam int NW_W = $clog2(memory_height) + 1;
  localparam logic [NW_W-1:0] MAX_WORDS = NW_W'(memory_height);

  state_e                      state_q;
  logic [NW_W-1:0]             num_q, idx_q;
  logic                        byte_ready_q, mem_we_q, busy_q, done_q, error_q;
  logic [addr_ins_width-1:0]   mem_addr_q;
  logic [memory_width-1:0]     mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [8*BYTES_PER_WORD-1:0] csum_q;
`endif

  logic                        start_acc, xfer, word_valid;
  logic [8*BYTES_PER_WORD-1:0] word;

  assign start_acc = start && (state_q == S_IDLE);
  assign xfer      = byte_valid && byte_ready_q;

  byte_assembler u_asm (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (start_acc),
    .byte_en_i    (xfer),
    .byte_i       (byte_data),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      num_q        <= '0;
      idx_q        <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          busy_q  <= 1'b1;
          error_q <= 1'b0;
          num_q   <= num_words;
          idx_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_q  <= '0;
`endif
          if (num_words == '0) begin
            state_q <= S_DONE;
          end else if (num_words > MAX_WORDS) begin
            error_q <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q      <= S_RECV;
            byte_ready_q <= 1'b1;
          end
        end
        S_RECV: if (word_valid) begin
          byte_ready_q <= 1'b0;
          mem_we_q     <= 1'b1;
          mem_addr_q   <= addr_ins_width'(idx_q);
          mem_wdata_q  <= memory_width'(word);
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_q       <= csum_q ^ word;
`endif
          state_q      <= S_WRITE;
        end
        S_WRITE: begin
          // idx_q stays at the last written index, so the address can never pass num_words-1
          if (idx_q + NW_W'(1) == num_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            byte_ready_q <= 1'b1;
            state_q      <= S_CHECK;
`else
            state_q      <= S_DONE;
`endif
          end else begin
            idx_q        <= idx_q + NW_W'(1);
            byte_ready_q <= 1'b1;
            state_q      <= S_RECV;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK: if (word_valid) begin
          byte_ready_q <= 1'b0;
          if (word != csum_q) error_q <= 1'b1;
          state_q      <= S_DONE;
        end
`endif
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign byte_ready = byte_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule
